// File: rtl/l2_mem_arbiter.sv
// rtl/l2_mem_arbiter.sv - L2 D/I memory-port arbiter onto one main-memory line port
// Fixed D priority by default; define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module l2_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              D_mem_read,
  input  logic              D_mem_write,
  input  logic [ADDR_W-1:0] D_mem_addr,
  input  logic [LINE_W-1:0] D_mem_wdata,
  output logic [LINE_W-1:0] D_mem_rdata,
  output logic              D_mem_ready,
  input  logic              I_mem_read,
  input  logic              I_mem_write,
  input  logic [ADDR_W-1:0] I_mem_addr,
  input  logic [LINE_W-1:0] I_mem_wdata,
  output logic [LINE_W-1:0] I_mem_rdata,
  output logic              I_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       d_grant_cnt,
  output logic [31:0]       i_grant_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic              lat_side;   // 0 = D, 1 = I
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              d_valid;
  logic              i_valid;
  logic              pick_i;
  logic              busy;
  logic              resp;

  // A side with both read and write high is malformed and never granted.
  assign d_valid = D_mem_read ^ D_mem_write;
  assign i_valid = I_mem_read ^ I_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;
  assign pick_i = i_valid & (~d_valid | rr_ptr);
`else
  assign pick_i = i_valid & ~d_valid;
`endif

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state       <= IDLE;
      lat_side    <= 1'b0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      D_mem_rdata <= '0;
      I_mem_rdata <= '0;
      d_grant_cnt <= '0;
      i_grant_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_valid || i_valid) begin
            lat_side  <= pick_i;
            lat_write <= pick_i ? I_mem_write : D_mem_write;
            lat_addr  <= pick_i ? I_mem_addr  : D_mem_addr;
            lat_wdata <= pick_i ? I_mem_wdata : D_mem_wdata;
            state     <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= ~pick_i;
`endif
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!lat_write) begin
              if (lat_side) I_mem_rdata <= mem_rdata;
              else          D_mem_rdata <= mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          // Requests still high here are L2's trailing copy and are not sampled.
          if (lat_side) i_grant_cnt <= i_grant_cnt + 32'd1;
          else          d_grant_cnt <= d_grant_cnt + 32'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from state so reset drops the memory request without waiting for a clock.
  assign busy        = (state == BUSY);
  assign resp        = (state == RESP);
  assign mem_read    = busy & ~lat_write;
  assign mem_write   = busy & lat_write;
  assign mem_addr    = busy ? lat_addr  : '0;
  assign mem_wdata   = busy ? lat_wdata : '0;
  assign D_mem_ready = resp & ~lat_side;
  assign I_mem_ready = resp & lat_side;

endmodule

// File: doc/l2_mem_arbiter.md
# l2_mem_arbiter

Merges the unified L2 cache's two memory-side ports (D-side and I-side) onto the single main-memory port. It grants one 128-bit line transfer at a time and holds the latched address and data stable toward memory until completion. It then returns a one-cycle ready pulse plus held read data to the requesting side, timed to the L2's registered-ready handshake. It sits between the L2 cache and main memory.

## Interface
- `ADDR_W`, default 28: line address width.
- `LINE_W`, default 128: line data width.
- `clk` input 1: clock, rising edge.
- `proc_reset_n` input 1: asynchronous, active-low reset.
- `D_mem_read`, `D_mem_write` input 1 each: D-side request from L2.
- `D_mem_addr` input ADDR_W: D-side line address.
- `D_mem_wdata` input LINE_W: D-side write line.
- `D_mem_rdata` output LINE_W: D-side read line, held.
- `D_mem_ready` output 1: D-side completion pulse.
- `I_mem_read`, `I_mem_write`, `I_mem_addr`, `I_mem_wdata`, `I_mem_rdata`, `I_mem_ready`: I-side equivalents, same widths and meanings.
- `mem_read`, `mem_write` output 1 each: memory request.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output LINE_W: memory write data.
- `mem_rdata` input LINE_W: memory read data, valid with `mem_ready`.
- `mem_ready` input 1: memory completion, one-cycle pulse.
- `d_grant_cnt`, `i_grant_cnt` output 32 each: completed transfers per side, wrap at 2^32.

## Operation
- States: IDLE, BUSY, RESP.
- **Request validity:** a side requests when exactly one of its read/write is high. If both are high, the request is ignored and never granted.
- **IDLE:**
  - If any valid request is present, pick a winner (see Configuration).
  - Latch the winner's side, op, address and write data, then go to BUSY.
- **BUSY:**
  - Drive `mem_read`/`mem_write` per the latched op, with `mem_addr`/`mem_wdata` taken from the latch.
  - Outputs stay stable regardless of upstream changes.
  - When `mem_ready`=1: on a read, capture `mem_rdata` into the winner's rdata register; go to RESP.
- **RESP:**
  - Memory request outputs are 0.
  - Assert the winner's `*_mem_ready` for exactly this cycle.
  - Increment the winner's grant counter.
  - Go to IDLE. All upstream requests seen in RESP are ignored; they are the stale trailing request from L2.
- **Read data:** each side's rdata register holds its value until that side's next read completion. A write completion does not modify it.
- **Memory outputs when not BUSY:** `mem_addr`/`mem_wdata` are 0.

## Timing
- **Reset values:** when `proc_reset_n`=0, immediately:
  - state IDLE, all outputs 0, rdata registers 0, counters 0, round-robin pointer = D.
- **Reset mid-transfer:** abandons the transfer with no ready pulse; memory request outputs drop asynchronously.
- **Grant:** a request sampled in IDLE at edge c drives memory from cycle c+1.
- **Completion:** `mem_ready` high in cycle t gives `*_mem_ready` high in cycle t+1 only, with rdata valid from t+1 and held. The arbiter is back in IDLE at t+2 and can grant a new request from either side.
- **Minimum occupancy:** 3 cycles per transfer (`mem_ready` returned in the first BUSY cycle).
- **Back-to-back:** a new request from the just-served side at t+2 (the L2 dirty-writeback-then-read sequence) is granted normally.
- **Simultaneous requests in IDLE:** one winner. The loser keeps its request asserted and is served next.
- **`mem_ready` outside BUSY:** ignored.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - **Defined:** round-robin. The pointer flips to the other side after each grant. On simultaneous requests the pointed-to side wins; a lone requester always wins.
  - **Undefined:** fixed priority. D always wins simultaneous requests, and the pointer logic is absent.

## Test plan
- **D read:** D read addr 0x0000010, memory returns 0xA5…A5 after 4 BUSY cycles.
  - `mem_read`=1 with `mem_addr`=0x0000010 for 4 cycles.
  - `D_mem_ready` pulses 1 cycle.
  - `D_mem_rdata`=0xA5…A5 held.
  - `d_grant_cnt`=1.
- **Dirty writeback then read (D side):** D write addr 0x0000020 with data 0x1234, then D read 0x0000030 issued in the cycle after the ready pulse.
  - Write seen on memory with exactly that data.
  - Read granted at t+2.
  - No duplicate write.
- **Simultaneous D and I reads, round-robin off:** D is served first, then I. Each side receives its own data, and I's rdata is unchanged during D's transfer.
- **Simultaneous D and I requests, three times, with `ARB_ROUND_ROBIN_EN`:** grants go D, I, D.
- **Both read and write high on the I side:** no memory activity and no `I_mem_ready` for 20 cycles.
- **Reset in the middle of BUSY:** `proc_reset_n` low in the middle of BUSY.
  - `mem_read` drops immediately and no ready pulse occurs.
  - Counters read 0.
  - The next request completes normally.
